// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: unit-addressed shared memory serving one read and one write per cycle,
// each chosen by its own round-robin arbiter over PORT_COUNT processor ports.
module shared_mem_arbiter #(
   parameter int PORT_COUNT = 4,
   parameter int BUS_SIZE   = 64,
   parameter int MEM_SIZE   = 1024,
   parameter int UNIT_SIZE  = 16,
   parameter int ADDR_SIZE  = 10
) (
   input  logic                                  i_clk,
   input  logic                                  i_rstn,
   input  logic [PORT_COUNT-1:0]                 i_req_rd,
   input  logic [PORT_COUNT-1:0]                 i_req_wr,
   input  logic [PORT_COUNT-1:0][BUS_SIZE-1:0]   i_proc_wr,
   input  logic [PORT_COUNT-1:0][2:0]            i_wr_size,
   input  logic [PORT_COUNT-1:0]                 i_wr_en,
   input  logic [PORT_COUNT-1:0][ADDR_SIZE-1:0]  i_proc_addr,
   output logic [PORT_COUNT-1:0]                 o_grant_rd,
   output logic [PORT_COUNT-1:0]                 o_grant_wr,
   output logic [BUS_SIZE-1:0]                   o_proc_rd
);
   localparam int UNITS = BUS_SIZE / UNIT_SIZE;
   localparam int PW = PORT_COUNT > 1 ? $clog2(PORT_COUNT) : 1;
   localparam int MW = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1;

   logic [UNIT_SIZE-1:0] mem [MEM_SIZE];
   logic [PW-1:0] rd_ptr, wr_ptr, rd_win, wr_win;
   logic [PW:0] rd_pick, wr_pick;
   logic rd_hit, wr_hit;
   logic [2:0] wr_sz;
   logic [3:0] wr_n;

   // returns {found, port}: first set bit of el searching upward from ptr with wrap
   function automatic logic [PW:0] pick(input logic [PORT_COUNT-1:0] el, input logic [PW-1:0] ptr);
      logic [PW:0] r;
      logic [PW-1:0] j;
      r = '0;
      for (int i = PORT_COUNT - 1; i >= 0; i--) begin
         j = PW'((int'(ptr) + i) % PORT_COUNT);
         if (el[j]) r = {1'b1, j};
      end
      return r;
   endfunction

   function automatic logic [MW-1:0] wrap(input logic [ADDR_SIZE-1:0] a, input int k);
      return MW'((int'(a) + k) % MEM_SIZE);
   endfunction

   // a port holding a grant this cycle sits out the next arbitration
   always_comb begin
      rd_pick = pick(i_req_rd & ~o_grant_rd, rd_ptr);
      wr_pick = pick(i_req_wr & ~o_grant_wr, wr_ptr);
      rd_hit  = rd_pick[PW];
      rd_win  = rd_pick[PW-1:0];
      wr_hit  = wr_pick[PW];
      wr_win  = wr_pick[PW-1:0];
      wr_sz   = i_wr_size[wr_win];
      wr_n    = (wr_sz == 3'd0 || int'(wr_sz) > UNITS) ? 4'(UNITS) : {1'b0, wr_sz};
   end

   // nonblocking memory update means a same-edge read sees the old contents
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_grant_rd <= '0;
         o_grant_wr <= '0;
         o_proc_rd  <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         for (int a = 0; a < MEM_SIZE; a++) mem[a] <= '0;
      end else begin
         o_grant_rd <= rd_hit ? PORT_COUNT'(1) << rd_win : '0;
         o_grant_wr <= wr_hit ? PORT_COUNT'(1) << wr_win : '0;
         if (rd_hit) begin
            rd_ptr <= PW'((int'(rd_win) + 1) % PORT_COUNT);
            for (int k = 0; k < UNITS; k++)
               o_proc_rd[k*UNIT_SIZE +: UNIT_SIZE] <= mem[wrap(i_proc_addr[rd_win], k)];
         end
         if (wr_hit) wr_ptr <= PW'((int'(wr_win) + 1) % PORT_COUNT);
         if (wr_hit && i_wr_en[wr_win])
            for (int k = 0; k < UNITS; k++)
               if (k < int'(wr_n))
                  mem[wrap(i_proc_addr[wr_win], k)] <= i_proc_wr[wr_win][k*UNIT_SIZE +: UNIT_SIZE];
      end
   end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: directed and randomized checks of shared_mem_arbiter against
// a queue-based scoreboard fed by a transaction-level memory/arbiter model.
module tb_shared_mem_arbiter;
   localparam int P = 4, B = 64, M = 1024, U = 16, A = 10;

   typedef struct packed {logic [3:0] g; logic [63:0] d;} rd_t;

   logic clk = 1'b0, rstn = 1'b0;
   logic [P-1:0] req_rd, req_wr, wr_en, grant_rd, grant_wr;
   logic [P-1:0][B-1:0] proc_wr;
   logic [P-1:0][2:0] wr_size;
   logic [P-1:0][A-1:0] proc_addr;
   logic [B-1:0] proc_rd;

   int checks = 0, failures = 0;
   logic [U-1:0] mm [M];
   int rptr, wptr;
   logic [P-1:0] m_grd, m_gwr;
   rd_t exp_rd[$];
   logic [P-1:0] exp_wr[$];
   rd_t e_rd;
   logic [P-1:0] e_wr;
   logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   always #5 clk = ~clk;

   shared_mem_arbiter dut (
      .i_clk(clk), .i_rstn(rstn), .i_req_rd(req_rd), .i_req_wr(req_wr),
      .i_proc_wr(proc_wr), .i_wr_size(wr_size), .i_wr_en(wr_en), .i_proc_addr(proc_addr),
      .o_grant_rd(grant_rd), .o_grant_wr(grant_wr), .o_proc_rd(proc_rd)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int find(input logic [P-1:0] el, input int ptr);
      for (int o = 0; o < P; o++) if (el[(ptr + o) % P]) return (ptr + o) % P;
      return -1;
   endfunction

   task automatic model_step();
      int rw, ww, n;
      rd_t r;
      rw = find(req_rd & ~m_grd, rptr);
      ww = find(req_wr & ~m_gwr, wptr);
      m_grd = '0;
      m_gwr = '0;
      if (rw >= 0) begin
         r.g = 4'(1 << rw);
         r.d = '0;
         for (int k = 0; k < 4; k++) r.d[k*16 +: 16] = mm[(int'(proc_addr[rw]) + k) % M];
         exp_rd.push_back(r);
         m_grd[rw] = 1'b1;
         rptr = (rw + 1) % P;
      end
      if (ww >= 0) begin
         n = (wr_size[ww] == 0 || wr_size[ww] > 4) ? 4 : int'(wr_size[ww]);
         if (wr_en[ww])
            for (int k = 0; k < n; k++) mm[(int'(proc_addr[ww]) + k) % M] = proc_wr[ww][k*16 +: 16];
         exp_wr.push_back(4'(1 << ww));
         m_gwr[ww] = 1'b1;
         wptr = (ww + 1) % P;
      end
   endtask

   task automatic tick(input bit keep = 1'b0);
      @(posedge clk);
      model_step();
      #1;
      if (!keep) begin
         req_rd &= ~m_grd;
         req_wr &= ~m_gwr;
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req_rd = '0; req_wr = '0; wr_en = '0;
      proc_wr = '0; wr_size = '0; proc_addr = '0;
      for (int a = 0; a < M; a++) mm[a] = '0;
      rptr = 0; wptr = 0; m_grd = '0; m_gwr = '0;
      exp_rd.delete();
      exp_wr.delete();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic drive_random();
      for (int p = 0; p < P; p++)
         if (!req_rd[p] && !req_wr[p]) begin
            proc_addr[p] = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'(1016 + $urandom_range(0, 7));
            proc_wr[p] = {$urandom, $urandom};
            wr_size[p] = 3'($urandom_range(0, 7));
            wr_en[p] = ($urandom_range(0, 3) != 0);
            req_rd[p] = ($urandom_range(0, 2) == 0);
            req_wr[p] = ($urandom_range(0, 2) == 0);
         end
   endtask

   always @(negedge clk) if (rstn) begin
      if (grant_rd != 0 || exp_rd.size() != 0) begin
         if (exp_rd.size() != 0) e_rd = exp_rd.pop_front();
         else e_rd = '0;
         chk("mon_grant_rd", 64'(grant_rd), 64'(e_rd.g));
         if (e_rd.g != 0) chk("mon_rd_data", proc_rd, e_rd.d);
      end
      if (grant_wr != 0 || exp_wr.size() != 0) begin
         if (exp_wr.size() != 0) e_wr = exp_wr.pop_front();
         else e_wr = '0;
         chk("mon_grant_wr", 64'(grant_wr), 64'(e_wr));
      end
   end

   initial begin
      do_reset();
      chk("reset_grant_rd", 64'(grant_rd), 0);
      chk("reset_grant_wr", 64'(grant_wr), 0);
      chk("reset_rd_data", proc_rd, 0);
      req_rd[0] = 1'b1; proc_addr[0] = 10'd0;
      tick();
      chk("t1_grant_rd", 64'(grant_rd), 64'b0001);
      chk("t1_rd_data", proc_rd, 0);
      proc_addr[1] = 10'd8; proc_wr[1] = 64'h4444_3333_2222_1111; wr_size[1] = 3'd0;
      wr_en[1] = 1'b1; req_wr[1] = 1'b1;
      tick();
      chk("t2_grant_wr", 64'(grant_wr), 64'b0010);
      proc_addr[2] = 10'd8; req_rd[2] = 1'b1;
      tick();
      chk("t2_grant_rd", 64'(grant_rd), 64'b0100);
      chk("t2_rd_data", proc_rd, 64'h4444_3333_2222_1111);
      do_reset();
      req_rd = '1;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1);
         chk("t3_rr_grant", 64'(grant_rd), 64'(seq[i]));
      end
      req_rd = '0;
      tick();
      proc_addr[0] = 10'd1022; proc_wr[0] = 64'hAAAA_BBBB_CCCC_DDDD; wr_size[0] = 3'd2;
      wr_en[0] = 1'b1; req_wr[0] = 1'b1;
      tick();
      chk("t4_grant_wr", 64'(grant_wr), 64'b0001);
      proc_addr[1] = 10'd1022; req_rd[1] = 1'b1;
      tick();
      chk("t4_grant_rd", 64'(grant_rd), 64'b0010);
      chk("t4_wrap_data", proc_rd, 64'h0000_0000_CCCC_DDDD);
      proc_addr[0] = 10'd4; req_rd[0] = 1'b1;
      proc_addr[3] = 10'd4; proc_wr[3] = '1; wr_size[3] = 3'd0; wr_en[3] = 1'b1; req_wr[3] = 1'b1;
      tick();
      chk("t5_grant_rd", 64'(grant_rd), 64'b0001);
      chk("t5_grant_wr", 64'(grant_wr), 64'b1000);
      chk("t5_old_data", proc_rd, 0);
      proc_addr[2] = 10'd4; req_rd[2] = 1'b1;
      tick();
      chk("t5_new_data", proc_rd, '1);
      proc_addr[1] = 10'd4; proc_wr[1] = 64'h1234; wr_size[1] = 3'd1; wr_en[1] = 1'b0; req_wr[1] = 1'b1;
      tick();
      chk("t6_grant_wr", 64'(grant_wr), 64'b0010);
      req_rd[0] = 1'b1;
      tick();
      chk("t6_grant_rd", 64'(grant_rd), 64'b0001);
      chk("t6_unchanged", proc_rd, '1);
      #1 rstn = 1'b0;
      #1;
      chk("t6_async_grant_rd", 64'(grant_rd), 0);
      chk("t6_async_grant_wr", 64'(grant_wr), 0);
      chk("t6_async_rd_data", proc_rd, 0);
      do_reset();
      repeat (3000) begin
         drive_random();
         tick();
      end
      req_rd = '0;
      req_wr = '0;
      repeat (3) tick();
      @(negedge clk);
      #1;
      chk("drain_rd_queue", 64'(exp_rd.size()), 0);
      chk("drain_wr_queue", 64'(exp_wr.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
